// File: rtl/alu_issue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : alu_issue_if                                                 |
// | Description : Instruction-in / ALU-operands-out handshake bundle.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface alu_issue_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instr;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  rs1_data;
   logic [XLEN-1:0]  rs2_data;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  op_a;
   logic [XLEN-1:0]  op_b;
   logic [3:0]       alu_func;
   logic [4:0]       rd;
   logic             illegal;
   logic [CNT_W-1:0] issue_count;

   modport master (
      output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
      input  in_ready, out_valid, op_a, op_b, alu_func, rd, illegal, issue_count
   );

   modport slave (
      input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
      output in_ready, out_valid, op_a, op_b, alu_func, rd, illegal, issue_count
   );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issue                                                    |
// | Description : RV32I OP/OP-IMM/LUI/AUIPC decode into one registered ALU     |
// |               issue slot with valid/ready and an issued-instruction count. |
// |               Macro ALU_ISSUE_UPPER_EN enables LUI/AUIPC decode.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_issue #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   alu_issue_if.slave bus
);

   localparam logic [3:0] c_ADD  = 4'd0;
   localparam logic [3:0] c_SUB  = 4'd1;
   localparam logic [3:0] c_AND  = 4'd2;
   localparam logic [3:0] c_OR   = 4'd3;
   localparam logic [3:0] c_XOR  = 4'd4;
   localparam logic [3:0] c_SLT  = 4'd5;
   localparam logic [3:0] c_SLTU = 4'd6;
   localparam logic [3:0] c_SLL  = 4'd7;
   localparam logic [3:0] c_SRL  = 4'd8;
   localparam logic [3:0] c_SRA  = 4'd9;

   localparam logic [6:0] c_OPC_OP    = 7'b0110011;
   localparam logic [6:0] c_OPC_IMM   = 7'b0010011;
   localparam logic [6:0] c_F7_BASE   = 7'b0000000;
   localparam logic [6:0] c_F7_ALT    = 7'b0100000;
`ifdef ALU_ISSUE_UPPER_EN
   localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
   localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;
`endif

   // funct3 -> function for the base (funct7 = 0) encodings shared by OP and OP-IMM
   function automatic logic [3:0] f3_func(input logic [2:0] f3);
      case (f3)
         3'b000:  return c_ADD;
         3'b001:  return c_SLL;
         3'b010:  return c_SLT;
         3'b011:  return c_SLTU;
         3'b100:  return c_XOR;
         3'b101:  return c_SRL;
         3'b110:  return c_OR;
         default: return c_AND;
      endcase
   endfunction

   logic [6:0]       w_opc;
   logic [2:0]       w_f3;
   logic [6:0]       w_f7;
   logic [XLEN-1:0]  w_imm_i;
   logic [XLEN-1:0]  w_shamt;
   logic             w_legal;
   logic [3:0]       w_func;
   logic [XLEN-1:0]  w_a;
   logic [XLEN-1:0]  w_b;
   logic             w_accept;
   logic             w_consume;

   logic             r_valid;
   logic [XLEN-1:0]  r_op_a;
   logic [XLEN-1:0]  r_op_b;
   logic [3:0]       r_func;
   logic [4:0]       r_rd;
   logic             r_ill;
   logic [CNT_W-1:0] r_cnt;

   assign w_opc   = bus.instr[6:0];
   assign w_f3    = bus.instr[14:12];
   assign w_f7    = bus.instr[31:25];
   assign w_imm_i = XLEN'($signed(bus.instr[31:20]));
   assign w_shamt = XLEN'(bus.instr[24:20]);

`ifdef ALU_ISSUE_UPPER_EN
   logic [XLEN-1:0] w_imm_u;
   assign w_imm_u = XLEN'($signed({bus.instr[31:12], 12'h000}));
`else
   logic w_unused_upper;
   assign w_unused_upper = ^{bus.pc, bus.instr[19:15]};
`endif

   always_comb begin
      w_legal = 1'b0;
      w_func  = c_ADD;
      w_a     = '0;
      w_b     = '0;
      case (w_opc)
         c_OPC_OP: begin
            w_a = bus.rs1_data;
            w_b = bus.rs2_data;
            if (w_f7 == c_F7_BASE) begin
               w_legal = 1'b1;
               w_func  = f3_func(w_f3);
            end else if (w_f7 == c_F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
               w_legal = 1'b1;
               w_func  = w_f3[2] ? c_SRA : c_SUB;
            end
         end
         c_OPC_IMM: begin
            w_a = bus.rs1_data;
            if (w_f3 == 3'b001) begin
               w_b     = w_shamt;
               w_legal = (w_f7 == c_F7_BASE);
               w_func  = c_SLL;
            end else if (w_f3 == 3'b101) begin
               w_b     = w_shamt;
               w_legal = (w_f7 == c_F7_BASE) || (w_f7 == c_F7_ALT);
               w_func  = w_f7[5] ? c_SRA : c_SRL;
            end else begin
               w_b     = w_imm_i;
               w_legal = 1'b1;
               w_func  = f3_func(w_f3);
            end
         end
`ifdef ALU_ISSUE_UPPER_EN
         c_OPC_LUI: begin
            w_b     = w_imm_u;
            w_legal = 1'b1;
         end
         c_OPC_AUIPC: begin
            w_a     = bus.pc;
            w_b     = w_imm_u;
            w_legal = 1'b1;
         end
`endif
         default: begin
            w_legal = 1'b0;
         end
      endcase
   end

   assign w_consume = r_valid && bus.out_ready;
   assign w_accept  = bus.in_valid && bus.in_ready;

   // Illegal instructions still occupy the slot but present all-zero payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_op_a  <= '0;
         r_op_b  <= '0;
         r_func  <= '0;
         r_rd    <= '0;
         r_ill   <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_op_a  <= w_legal ? w_a : '0;
         r_op_b  <= w_legal ? w_b : '0;
         r_func  <= w_legal ? w_func : 4'd0;
         r_rd    <= w_legal ? bus.instr[11:7] : 5'd0;
         r_ill   <= !w_legal;
      end else if (w_consume) begin
         r_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_consume && !r_ill) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign bus.in_ready    = !r_valid || bus.out_ready;
   assign bus.out_valid   = r_valid;
   assign bus.op_a        = r_op_a;
   assign bus.op_b        = r_op_b;
   assign bus.alu_func    = r_func;
   assign bus.rd          = r_rd;
   assign bus.illegal     = r_ill;
   assign bus.issue_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_issue                                                 |
// | Description : Directed + randomized bench for alu_issue with a queue-based |
// |               reference model. Honours ALU_ISSUE_UPPER_EN.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_issue;

   typedef struct packed {
      logic        ill;
      logic [3:0]  func;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
   } dec_t;

`ifdef ALU_ISSUE_UPPER_EN
   localparam bit c_UPPER = 1'b1;
`else
   localparam bit c_UPPER = 1'b0;
`endif
   localparam int c_F3_FN [8] = '{0, 7, 5, 6, 4, 8, 3, 2};

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   failures = 0;

   dec_t        q[$];
   logic [31:0] m_cnt = '0;
   logic [31:0] c0;

   alu_issue_if #(.XLEN(32), .CNT_W(32)) bus ();

   alu_issue #(.XLEN(32), .CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic dec_t model_dec(input logic [31:0] ins, input logic [31:0] p,
                                      input logic [31:0] r1, input logic [31:0] r2);
      dec_t        d  = '0;
      int          fn = -1;
      logic [6:0]  f7 = ins[31:25];
      logic [2:0]  f3 = ins[14:12];
      logic [31:0] u  = {ins[31:12], 12'h000};
      if (ins[6:0] == 7'h33) begin
         d.a = r1;
         d.b = r2;
         if (f7 == 7'h00) fn = c_F3_FN[f3];
         else if (f7 == 7'h20 && f3 == 3'd0) fn = 1;
         else if (f7 == 7'h20 && f3 == 3'd5) fn = 9;
      end else if (ins[6:0] == 7'h13) begin
         d.a = r1;
         if (f3 == 3'd1 || f3 == 3'd5) begin
            d.b = 32'(ins[24:20]);
            if (f7 == 7'h00) fn = c_F3_FN[f3];
            else if (f7 == 7'h20 && f3 == 3'd5) fn = 9;
         end else begin
            d.b = 32'($signed(ins[31:20]));
            fn  = c_F3_FN[f3];
         end
      end else if (c_UPPER && ins[6:0] == 7'h37) begin
         d.b = u;
         fn  = 0;
      end else if (c_UPPER && ins[6:0] == 7'h17) begin
         d.a = p;
         d.b = u;
         fn  = 0;
      end
      if (fn < 0) begin
         d     = '0;
         d.ill = 1'b1;
      end else begin
         d.func = 4'(fn);
         d.rd   = ins[11:7];
      end
      return d;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r = $urandom;
      case ($urandom_range(0, 5))
         0, 1:    r[6:0] = 7'h33;
         2, 3:    r[6:0] = 7'h13;
         4:       r[6:0] = ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17;
         default: ;
      endcase
      case ($urandom_range(0, 2))
         0:       r[31:25] = 7'h00;
         1:       r[31:25] = 7'h20;
         default: ;
      endcase
      return r;
   endfunction

   // Reference: at most one item in flight; consume pops, accept pushes.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_cnt <= '0;
      end else begin
         logic acc;
         acc = bus.in_valid && (q.size() == 0 || bus.out_ready);
         if (q.size() != 0 && bus.out_ready) begin
            if (!q[0].ill) m_cnt <= m_cnt + 32'd1;
            void'(q.pop_front());
         end
         if (acc) q.push_back(model_dec(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data));
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
         chk("m_in_ready", 32'(bus.in_ready), 32'((q.size() == 0) || bus.out_ready));
         chk("m_issue_count", bus.issue_count, m_cnt);
         if (q.size() != 0) begin
            chk("m_illegal", 32'(bus.illegal), 32'(q[0].ill));
            chk("m_alu_func", 32'(bus.alu_func), 32'(q[0].func));
            chk("m_op_a", bus.op_a, q[0].a);
            chk("m_op_b", bus.op_b, q[0].b);
            chk("m_rd", 32'(bus.rd), 32'(q[0].rd));
         end
      end
   end

   task automatic send(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
      bus.in_valid = 1'b1;
      bus.instr    = i;
      bus.pc       = p;
      bus.rs1_data = a;
      bus.rs2_data = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic chk_out(input string nm, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r, input logic il);
      chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({nm, "_func"}, 32'(bus.alu_func), 32'(f));
      chk({nm, "_op_a"}, bus.op_a, a);
      chk({nm, "_op_b"}, bus.op_b, b);
      chk({nm, "_rd"}, 32'(bus.rd), 32'(r));
      chk({nm, "_illegal"}, 32'(bus.illegal), 32'(il));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.instr     = '0;
      bus.pc        = '0;
      bus.rs1_data  = '0;
      bus.rs2_data  = '0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_issue_count", bus.issue_count, 32'd0);
      chk("rst_illegal", 32'(bus.illegal), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed decode with literal expectations
      bus.out_ready = 1'b1;
      send(32'h002081B3, 32'h0, 32'd5, 32'd7);
      chk_out("add", 4'd0, 32'd5, 32'd7, 5'd3, 1'b0);
      chk("add_cnt", bus.issue_count, 32'd0);
      send(32'h402081B3, 32'h0, 32'd5, 32'd7);
      chk_out("sub", 4'd1, 32'd5, 32'd7, 5'd3, 1'b0);
      chk("sub_cnt", bus.issue_count, 32'd1);
      send(32'h40435293, 32'h0, 32'h80000000, 32'd0);
      chk_out("srai", 4'd9, 32'h80000000, 32'd4, 5'd5, 1'b0);
      chk("srai_cnt", bus.issue_count, 32'd2);
      send(32'hFFF00093, 32'h0, 32'd0, 32'd0);
      chk_out("addi", 4'd0, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b0);
      chk("addi_cnt", bus.issue_count, 32'd3);
      send(32'h123450B7, 32'h1000, 32'd9, 32'd9);
      if (c_UPPER) chk_out("lui", 4'd0, 32'd0, 32'h12345000, 5'd1, 1'b0);
      else         chk_out("lui", 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);
      chk("lui_cnt", bus.issue_count, 32'd4);
      send(32'h00000000, 32'h0, 32'd3, 32'd4);
      chk_out("zero", 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);
      chk("zero_cnt", bus.issue_count, 32'd4 + 32'(c_UPPER));
      send(32'h402091B3, 32'h0, 32'd3, 32'd4);
      chk_out("sll_alt", 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);
      chk("sll_alt_cnt", bus.issue_count, 32'd4 + 32'(c_UPPER));
      @(posedge clk);
      #1;
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_cnt", bus.issue_count, 32'd4 + 32'(c_UPPER));

      // Backpressure: slot stays frozen while downstream stalls
      bus.out_ready = 1'b0;
      send(32'h002081B3, 32'h0, 32'd11, 32'd22);
      bus.in_valid = 1'b1;
      bus.instr    = 32'h40435293;
      bus.rs1_data = 32'd99;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk_out("bp_hold", 4'd0, 32'd11, 32'd22, 5'd3, 1'b0);
      end
      c0 = m_cnt;
      bus.out_ready = 1'b1;
      bus.instr     = 32'h002081B3;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         chk("b2b_cnt", bus.issue_count, c0 + 32'(k));
         chk("b2b_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("b2b_drain_cnt", bus.issue_count, c0 + 32'd6);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.out_ready = ($urandom_range(0, 9) < 7);
         bus.instr     = rand_instr();
         bus.pc        = $urandom;
         bus.rs1_data  = $urandom;
         bus.rs2_data  = $urandom;
         @(posedge clk);
         #1;
      end

      // Asynchronous reset while a stalled result is held
      bus.out_ready = 1'b0;
      send(32'h002081B3, 32'h0, 32'd1, 32'd2);
      chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_cnt", bus.issue_count, 32'd0);
      chk("arst_op_a", bus.op_a, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(32'h002081B3, 32'h0, 32'd5, 32'd7);
      chk_out("post_rst", 4'd0, 32'd5, 32'd7, 5'd3, 1'b0);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_cnt", bus.issue_count, 32'd1);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
